// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: machine word, cache controller states and the direct-mapped frame.
// Frame tags are sized for the smallest legal index (2 sets); caches zero-extend narrower tags.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // 32 address bits - 2 offset bits - at least 1 index bit
  localparam int FRAME_TAG_W = 29;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } cache_state_t;

  typedef struct packed {
    logic                   valid;
    logic [FRAME_TAG_W-1:0] tag;
    word_t                  data;
  } icache_frame_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame, read-only instruction cache.
// Latency: hit is combinational in IDLE; a miss costs one IDLE cycle plus (wait+1) FETCH cycles.
// Backpressure: the fill waits on iwait with iREN/iaddr held; ihit stays low until the fill lands.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IDXW = $clog2(NSETS);

  cache_state_t  state, next_state;
  word_t         miss_addr;
  icache_frame_t frames [NSETS];

  logic [IDXW-1:0]        req_idx, miss_idx;
  logic [FRAME_TAG_W-1:0] req_tag, miss_tag;
  logic                   hit, miss, fill;

  assign req_idx  = imemaddr[IDXW+1:2];
  assign req_tag  = FRAME_TAG_W'(imemaddr >> (IDXW + 2));
  assign miss_idx = miss_addr[IDXW+1:2];
  assign miss_tag = FRAME_TAG_W'(miss_addr >> (IDXW + 2));

  assign hit  = (state == IDLE) && imemREN && frames[req_idx].valid
                && (frames[req_idx].tag == req_tag);
  assign miss = (state == IDLE) && imemREN && !hit;

  assign ihit     = hit;
  assign imemload = hit ? frames[req_idx].data : '0;

  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    iaddr      = '0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (miss) next_state = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Only the valid bits reset; a reset edge in FETCH drops the pending fill.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      for (int i = 0; i < NSETS; i++) frames[i].valid <= 1'b0;
    end else begin
      state <= next_state;
      if (miss) miss_addr <= word_align(imemaddr);
      if (fill) frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a scoreboard checks every ihit word, stimulus checks miss/fill timing.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int tests = 0;
  int fails = 0;
  word_t exp_q [$];

  always #5 CLK = ~CLK;

  icache #(.NSETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  // Backing memory contents
  function automatic word_t memval(input word_t a);
    if (a == 32'h0) return 32'h3C010001;
    return {16'hBEEF, a[15:0]};
  endfunction

  assign iload = memval(iaddr);

  task automatic chk(input string name, input word_t got, input word_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented hit must match the next expected word.
  always @(negedge CLK) begin : monitor
    word_t e;
    if (ihit === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_hit: imemaddr %h data %h at %0t", imemaddr, imemload, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_hit_data", imemload, e);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic hit_read(input word_t a);
    imemREN  = 1'b1;
    imemaddr = a;
    exp_q.push_back(memval({a[31:2], 2'b00}));
    @(negedge CLK);
    chk("hit_ihit", {31'b0, ihit}, 32'd1);
    chk("hit_iren", {31'b0, iREN}, 32'd0);
    step();
  endtask

  task automatic miss_cycle(input word_t a);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    @(negedge CLK);
    chk("miss_ihit", {31'b0, ihit}, 32'd0);
    chk("miss_load", imemload, 32'h0);
    chk("miss_iren", {31'b0, iREN}, 32'd0);
    step();
  endtask

  task automatic fetch_cycle(input word_t a, input logic w);
    iwait = w;
    @(negedge CLK);
    chk("fetch_iren", {31'b0, iREN}, 32'd1);
    chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
    chk("fetch_ihit", {31'b0, ihit}, 32'd0);
    step();
  endtask

  task automatic miss_fill(input word_t a, input int waits);
    miss_cycle(a);
    for (int w = 0; w <= waits; w++) fetch_cycle(a, w < waits);
    iwait = 1'b1;
    hit_read(a);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    step();
    step();
    @(negedge CLK);
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_load", imemload, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    step();
    nRST = 1'b1;

    // First fetch of 0x0 with zero-wait memory: hit on the third cycle
    miss_fill(32'h0, 0);
    // Re-read hits immediately, also with ignored offset bits
    hit_read(32'h0);
    hit_read(32'h3);

    // imemREN low: no hit even on a valid frame
    imemREN = 1'b0;
    @(negedge CLK);
    chk("noren_ihit", {31'b0, ihit}, 32'd0);
    chk("noren_iren", {31'b0, iREN}, 32'd0);
    step();

    // Conflict on index 0: 0x40 evicts 0x0
    miss_fill(32'h40, 0);
    miss_fill(32'h0, 0);

    // Five wait cycles; request held stable, frame written on the sixth FETCH cycle
    miss_fill(32'h24, 5);
    hit_read(32'h0);

    // Branch mid-FETCH: 0x4 still fills, 0x80 then misses, 0x4 hits afterwards
    miss_cycle(32'h4);
    fetch_cycle(32'h4, 1'b1);
    imemaddr = 32'h80;
    fetch_cycle(32'h4, 1'b0);
    miss_fill(32'h80, 1);
    hit_read(32'h4);

    // imemREN dropped during FETCH: fill still completes
    miss_cycle(32'h10);
    imemREN = 1'b0;
    fetch_cycle(32'h10, 1'b1);
    fetch_cycle(32'h10, 1'b0);
    hit_read(32'h10);

    // Reset during FETCH aborts the fill and clears all frames
    miss_cycle(32'h8);
    nRST = 1'b0;
    fetch_cycle(32'h8, 1'b0);
    @(negedge CLK);
    chk("rstfetch_iren", {31'b0, iREN}, 32'd0);
    chk("rstfetch_iaddr", iaddr, 32'h0);
    step();
    nRST = 1'b1;
    miss_fill(32'h8, 0);
    miss_fill(32'h10, 0);

    imemREN = 1'b0;
    step();
    step();
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
